// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I subset core: sequences fetch, decode, memory,
// ALU and branch steps, with wait states on mem_ready and an absorbing TRAP state.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       Carry,
    input  logic       Overflow,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_q, state_d;

    logic pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw, mem_req_raw;
    logic arith_bad_f3, branch_bad_f3;

    // Shared R/I-type funct3 map; sub_ok is false for immediates since Instr[30] is immediate data there.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'b000:  alu_decode = sub_ok ? ALU_SUB : ALU_ADD;
            3'b010:  alu_decode = ALU_SLT;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n,
                                          input logic c, input logic v);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = !z;
            3'b100:  branch_taken = n ^ v;
            3'b101:  branch_taken = !(n ^ v);
            3'b110:  branch_taken = !c;
            3'b111:  branch_taken = c;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    assign arith_bad_f3  = (funct3 == 3'b001) || (funct3 == 3'b011) ||
                           (funct3 == 3'b100) || (funct3 == 3'b101);
    assign branch_bad_f3 = (funct3 == 3'b010) || (funct3 == 3'b011);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        mem_req_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ImmSrc        = 3'b000;
        ALUControl    = ALU_ADD;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_raw = 1'b1;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    ALUSrcB      = 2'b10;
                    ResultSrc    = 2'b10;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while the opcode is decoded.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = arith_bad_f3  ? S_TRAP : S_EXECR;
                    OP_ITYPE:     state_d = arith_bad_f3  ? S_TRAP : S_EXECI;
                    OP_BRANCH:    state_d = branch_bad_f3 ? S_TRAP : S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                AdrSrc      = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7b5);
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct3, 1'b0);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA      = 2'b10;
                ALUControl   = ALU_SUB;
                pc_write_raw = branch_taken(funct3, Zero, Negative, Carry, Overflow);
                state_d      = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // Strobes are squashed while reset is held so an interrupted access never commits.
    assign PCWrite  = reset & pc_write_raw;
    assign IRWrite  = reset & ir_write_raw;
    assign RegWrite = reset & reg_write_raw;
    assign MemWrite = reset & mem_write_raw;
    assign MemReq   = reset & mem_req_raw;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle
// against hand-derived state and strobe values.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, Negative, Carry, Overflow;
    logic       mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, MemReq, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic [3:0] state;
    logic       illegal;
    logic [5:0] strobes;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .Negative   (Negative),
        .Carry      (Carry),
        .Overflow   (Overflow),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .MemReq     (MemReq),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // {PCWrite, IRWrite, RegWrite, MemWrite, MemReq, AdrSrc}
    assign strobes = {PCWrite, IRWrite, RegWrite, MemWrite, MemReq, AdrSrc};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [3:0] es, input logic [5:0] ek);
        #1;
        check({tag, ".state"}, 32'(state), 32'(es));
        check({tag, ".strobes"}, 32'(strobes), 32'(ek));
        $display("%0t %s state=%0d strobes=%b", $time, tag, state, strobes);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    // From FETCH with mem_ready=1: checks FETCH and DECODE, leaves FSM in the execute state.
    task automatic fetch_decode(input string tag);
        mem_ready = 1'b1;
        look({tag, ".fetch"}, 4'd0, 6'b110010);
        check({tag, ".fetch.ressrc"}, 32'(ResultSrc), 32'h2);
        check({tag, ".fetch.srcb"}, 32'(ALUSrcB), 32'h2);
        tick();
        look({tag, ".decode"}, 4'd1, 6'b000000);
        check({tag, ".decode.imm"}, 32'(ImmSrc), 32'h2);
        check({tag, ".decode.srca"}, 32'(ALUSrcA), 32'h1);
        tick();
    endtask

    task automatic do_branch(input string tag, input logic [2:0] f3, input logic z, input logic n,
                             input logic c, input logic v, input logic exp_pc);
        set_instr(7'b1100011, f3, 1'b0);
        Zero = z; Negative = n; Carry = c; Overflow = v;
        fetch_decode(tag);
        look({tag, ".branch"}, 4'd9, {exp_pc, 5'b00000});
        check({tag, ".branch.alu"}, 32'(ALUControl), 32'h1);
        tick();
        look({tag, ".next"}, 4'd0, 6'b110010);
        Zero = 0; Negative = 0; Carry = 0; Overflow = 0;
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b1;
        Zero = 0; Negative = 0; Carry = 0; Overflow = 0;
        set_instr(7'b0000011, 3'b010, 1'b0);

        // Reset with mem_ready high: strobes must be squashed.
        tick();
        look("reset", 4'd0, 6'b000000);
        tick();
        reset = 1'b1;

        // lw, no wait states: 0,1,2,3,4,0
        fetch_decode("lw");
        look("lw.memadr", 4'd2, 6'b000000);
        check("lw.memadr.imm", 32'(ImmSrc), 32'h0);
        tick();
        look("lw.memread", 4'd3, 6'b000011);
        tick();
        look("lw.memwb", 4'd4, 6'b001000);
        check("lw.memwb.ressrc", 32'(ResultSrc), 32'h1);
        tick();

        // sw with three wait cycles in MEMWRITE, then a FETCH wait state
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_decode("sw");
        look("sw.memadr", 4'd2, 6'b000000);
        check("sw.memadr.imm", 32'(ImmSrc), 32'h1);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            look($sformatf("sw.wait%0d", i), 4'd5, 6'b000111);
            tick();
        end
        mem_ready = 1'b1;
        look("sw.memwrite", 4'd5, 6'b000111);
        tick();
        mem_ready = 1'b0;
        look("fetchwait0", 4'd0, 6'b000010);
        tick();
        look("fetchwait1", 4'd0, 6'b000010);

        // Branches
        do_branch("beq", 3'b000, 1, 0, 0, 0, 1'b1);
        do_branch("bne", 3'b001, 1, 0, 0, 0, 1'b0);
        do_branch("blt", 3'b100, 0, 1, 0, 0, 1'b1);
        do_branch("bgeu", 3'b111, 0, 0, 0, 0, 1'b0);

        // R-type sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        fetch_decode("sub");
        look("sub.execr", 4'd6, 6'b000000);
        check("sub.alu", 32'(ALUControl), 32'h1);
        check("sub.srca", 32'(ALUSrcA), 32'h2);
        check("sub.srcb", 32'(ALUSrcB), 32'h0);
        tick();
        look("sub.aluwb", 4'd8, 6'b001000);
        check("sub.aluwb.ressrc", 32'(ResultSrc), 32'h0);
        tick();

        // R-type or
        set_instr(7'b0110011, 3'b110, 1'b0);
        fetch_decode("or");
        look("or.execr", 4'd6, 6'b000000);
        check("or.alu", 32'(ALUControl), 32'h3);
        tick();
        tick();

        // addi with Instr[30]=1 is still add
        set_instr(7'b0010011, 3'b000, 1'b1);
        fetch_decode("addi");
        look("addi.execi", 4'd7, 6'b000000);
        check("addi.alu", 32'(ALUControl), 32'h0);
        check("addi.srcb", 32'(ALUSrcB), 32'h1);
        check("addi.imm", 32'(ImmSrc), 32'h0);
        tick();
        look("addi.aluwb", 4'd8, 6'b001000);
        tick();

        // slti
        set_instr(7'b0010011, 3'b010, 1'b0);
        fetch_decode("slti");
        look("slti.execi", 4'd7, 6'b000000);
        check("slti.alu", 32'(ALUControl), 32'h5);
        tick();
        tick();

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        fetch_decode("jal");
        look("jal.jal", 4'd10, 6'b100000);
        check("jal.srca", 32'(ALUSrcA), 32'h1);
        check("jal.srcb", 32'(ALUSrcB), 32'h2);
        tick();
        look("jal.aluwb", 4'd8, 6'b001000);
        tick();

        // lui is unsupported: TRAP held for 10 cycles, cleared by one reset edge
        set_instr(7'b0110111, 3'b000, 1'b0);
        fetch_decode("lui");
        for (int i = 0; i < 10; i++) begin
            look($sformatf("lui.trap%0d", i), 4'd15, 6'b000000);
            check($sformatf("lui.illegal%0d", i), 32'(illegal), 32'h1);
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        look("lui.reset", 4'd0, 6'b110010);
        check("lui.reset.illegal", 32'(illegal), 32'h0);

        // R-type funct3=001 traps
        set_instr(7'b0110011, 3'b001, 1'b0);
        fetch_decode("sll");
        look("sll.trap", 4'd15, 6'b000000);
        check("sll.illegal", 32'(illegal), 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Reset during a MEMREAD wait state abandons the access
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_decode("lwrst");
        tick();
        mem_ready = 1'b0;
        look("lwrst.wait", 4'd3, 6'b000011);
        tick();
        reset = 1'b0;
        look("lwrst.inreset", 4'd3, 6'b000001);
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        look("lwrst.fetch", 4'd0, 6'b110010);
        tick();
        look("lwrst.decode", 4'd1, 6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-low reset.
REQ-002 SHALL have inputs: op 7 (Instr[6:0]); funct3 3 (Instr[14:12]); funct7b5 1 (Instr[30]); Zero, Negative, Carry, Overflow 1 each (ALU flags); mem_ready 1 (memory completes the current access this cycle).
REQ-003 SHALL have outputs: PCWrite 1; IRWrite 1; RegWrite 1; MemWrite 1; MemReq 1; AdrSrc 1 (0=PC, 1=ALUOut).
REQ-004 SHALL have outputs: ResultSrc 2 (00=ALUOut, 01=ReadData, 10=ALUResult); ALUSrcA 2 (00=PC, 01=OldPC, 10=rs1 reg); ALUSrcB 2 (00=rs2 reg, 01=ImmExt, 10=const 4).
REQ-005 SHALL have outputs: ImmSrc 3 (000=I, 001=S, 010=B, 011=J); ALUControl 3 (000=add, 001=sub, 010=and, 011=or, 101=slt); state 4 (debug); illegal 1.

Function
REQ-006 SHALL be a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=15. mem_ready SHALL qualify only the FETCH, MEMREAD and MEMWRITE states.
REQ-007 Every output not listed for a state SHALL be 0. illegal SHALL be 1 only in TRAP.
REQ-008 FETCH: MemReq=1, AdrSrc=0. While mem_ready=0, all other outputs SHALL be 0 and the FSM SHALL stay in FETCH. When mem_ready=1: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10, and the next state SHALL be DECODE.
REQ-009 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010, add. Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- any other op -> TRAP
REQ-010 DECODE SHALL also go to TRAP for these encodings:
- R/I-type with funct3 in {001,011,100,101}
- I-type with funct3=000 and funct7b5=1 is NOT illegal (it is addi)
- branch with funct3 in {010,011}
REQ-011 MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=000 for lw (next state MEMREAD); ImmSrc=001 for sw (next state MEMWRITE).
REQ-012 MEMREAD: MemReq=1, AdrSrc=1. Stay until mem_ready=1, then go to MEMWB.
REQ-013 MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
REQ-014 MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1, held every cycle until mem_ready=1. Next state FETCH.
REQ-015 EXECR: ALUSrcA=10, ALUSrcB=00. ALUControl by funct3:
- 000 -> sub if funct7b5 else add
- 010 -> slt
- 110 -> or
- 111 -> and
Next state ALUWB.
REQ-016 EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000. Same funct3 map as EXECR, but funct3=000 SHALL always give add. Next state ALUWB.
REQ-017 ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
REQ-018 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite SHALL equal the taken condition, evaluated combinationally this cycle:
- 000 -> Zero
- 001 -> !Zero
- 100 -> Negative^Overflow
- 101 -> !(Negative^Overflow)
- 110 -> !Carry
- 111 -> Carry
Next state FETCH.
REQ-019 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next state ALUWB, which writes OldPC+4 to rd.
REQ-020 TRAP SHALL be absorbing until reset, with all strobes 0.
REQ-021 Latency excluding wait states: lw=5, sw=4, R/I=4, branch=3, jal=4 cycles. Each FETCH, MEMREAD or MEMWRITE cycle with mem_ready=0 SHALL add exactly one cycle.
REQ-022 At most one of {RegWrite, MemWrite} SHALL be 1 in any cycle. PCWrite SHALL be 1 at most once per instruction outside FETCH.

Reset
REQ-023 When reset=0 at a rising edge, state SHALL become FETCH regardless of current state, including wait states and TRAP.
REQ-024 While reset=0, PCWrite, IRWrite, RegWrite, MemWrite and MemReq SHALL be forced to 0 combinationally.
REQ-025 On the first edge with reset=1, the FSM SHALL evaluate FETCH normally. A memory access interrupted by reset SHALL be abandoned, not resumed.

Verification
REQ-026 Reset, then lw (op 0000011) with mem_ready=1 always -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4, with ResultSrc=01.
REQ-027 sw with mem_ready held 0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles; FETCH follows; RegWrite never 1.
REQ-028 Branch cases, each taking 3 cycles:
- beq with Zero=1 -> PCWrite=1 in BRANCH
- bne with Zero=1 -> PCWrite=0 in BRANCH
- blt with Negative=1, Overflow=0 -> PCWrite=1
- bgeu with Carry=0 -> PCWrite=0
REQ-029 R-type funct3=000, funct7b5=1 -> ALUControl=001 in EXECR. addi with Instr[30]=1 -> ALUControl=000 in EXECI.
REQ-030 op=0110111, or R-type funct3=001 -> TRAP (state=15, illegal=1) held for 10 cycles; reset=0 for one edge -> state=0, illegal=0.
REQ-031 reset=0 asserted in MEMREAD while waiting -> next state 0; MemReq=0 during the reset cycle; a normal fetch follows.
